// File: rtl/parent_link_tx_framer.sv
// parent_link_tx_framer: serialises 64-bit parent_tx messages into 6-beat 16-bit link frames (header, 4 data, XOR trailer)
module parent_link_tx_framer #(
  parameter logic [7:0] SOF_MARKER = 8'hA5,
  parameter int SEQ_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [15:0]          link_data,
  output logic                 link_valid,
  input  logic                 link_ready,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [2:0] beat;
  logic [SEQ_WIDTH-1:0] seq, seq_n;
  logic [63:0] msg;
  logic [15:0] hdr, hdr_n, csum, nxt;
  logic last_ack, accept;
  assign last_ack = state == SEND && beat == 3'd5 && link_ready;
  assign in_ready = state == IDLE || last_ack;
  assign accept = in_valid && in_ready;
  assign busy = state == SEND;
  assign seq_n = last_ack ? seq + SEQ_WIDTH'(1) : seq;
  assign hdr = {SOF_MARKER, 8'h00} | 16'(seq);
  // a back-to-back frame is headed with the sequence number after the one just finished
  assign hdr_n = {SOF_MARKER, 8'h00} | 16'(seq_n);
  assign csum = hdr ^ msg[63:48] ^ msg[47:32] ^ msg[31:16] ^ msg[15:0];
  assign nxt = beat == 3'd0 ? msg[63:48] :
               beat == 3'd1 ? msg[47:32] :
               beat == 3'd2 ? msg[31:16] :
               beat == 3'd3 ? msg[15:0]  : csum;
  always_comb begin
    state_n = state;
    if (accept) state_n = SEND;
    else if (last_ack) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat <= 3'd0;
      seq <= '0;
      frame_count <= '0;
      msg <= 64'h0;
      link_data <= 16'h0000;
      link_valid <= 1'b0;
    end else begin
      if (accept) begin
        msg <= in_data;
        link_data <= hdr_n;
        link_valid <= 1'b1;
        beat <= 3'd0;
      end else if (last_ack) begin
        link_valid <= 1'b0;
      end else if (state == SEND && link_ready) begin
        beat <= beat + 3'd1;
        link_data <= nxt;
      end
      if (last_ack) begin
        seq <= seq_n;
        frame_count <= frame_count + CNT_WIDTH'(1);
      end
    end
  end
endmodule
